// File: rtl/err_monitor_pkg.sv
// Shared types and constants for the err_monitor bit-error statistics block.
package err_monitor_pkg;

    localparam int BURST_W = 8;
    localparam int HIST_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        ALARM = 2'd2
    } state_t;

endpackage

// File: rtl/err_monitor_popcount.sv
// bit_popcount: purely combinational count of the set bits in an N-bit word.
module bit_popcount #(
    parameter int N = 5
) (
    input  logic [N-1:0]             data_i,
    output logic [$clog2(N+1)-1:0]   count_o
);

    localparam int W = $clog2(N + 1);

    // NOTE: assign a default before the loop so every path drives count_o and no latch is inferred.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < N; i++) begin
            count_o = count_o + W'(data_i[i]);
        end
    end

endmodule

// File: rtl/err_monitor.sv
// err_monitor: compares a received stream against its reference and keeps error statistics.
// Optional per-bit position histogram is built when ERR_MONITOR_POS_HIST_EN is defined.
module err_monitor
    import err_monitor_pkg::*;
#(
    parameter int N        = 5,
    parameter int CNT_W    = 16,
    parameter int BURST_TH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [N-1:0]          ref_word,
    input  logic [N-1:0]          rx_word,
    input  logic                  clear,
    output logic [CNT_W-1:0]      word_cnt,
    output logic [CNT_W-1:0]      word_err_cnt,
    output logic [CNT_W-1:0]      bit_err_cnt,
    output logic [BURST_W-1:0]    burst_len,
    output logic [BURST_W-1:0]    max_burst,
    output logic [N-1:0]          last_err,
    output logic                  alarm,
    output logic [1:0]            state
`ifdef ERR_MONITOR_POS_HIST_EN
   ,output logic [N*HIST_W-1:0]   pos_hist
`endif
);

    localparam int PC_W  = $clog2(N + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [N-1:0]       diff;
    logic [PC_W-1:0]    pc;
    logic               err;
    logic [SUM_W-1:0]   bit_sum;

    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]   word_err_cnt_q, word_err_cnt_d;
    logic [CNT_W-1:0]   bit_err_cnt_q, bit_err_cnt_d;
    logic [BURST_W-1:0] burst_len_q, burst_len_d;
    logic [BURST_W-1:0] max_burst_q, max_burst_d;
    logic [N-1:0]       last_err_q, last_err_d;
    state_t             state_q, state_d;

    assign diff    = rx_word ^ ref_word;
    assign err     = |diff;
    assign bit_sum = SUM_W'(bit_err_cnt_q) + SUM_W'(pc);

    bit_popcount #(.N(N)) u_popcount (
        .data_i  (diff),
        .count_o (pc)
    );

    // Statistics datapath; clear outranks valid so a coincident sample is dropped.
    always_comb begin
        word_cnt_d     = word_cnt_q;
        word_err_cnt_d = word_err_cnt_q;
        bit_err_cnt_d  = bit_err_cnt_q;
        burst_len_d    = burst_len_q;
        max_burst_d    = max_burst_q;
        last_err_d     = last_err_q;
        if (clear) begin
            word_cnt_d     = '0;
            word_err_cnt_d = '0;
            bit_err_cnt_d  = '0;
            burst_len_d    = '0;
            max_burst_d    = '0;
            last_err_d     = '0;
        end else if (valid) begin
            if (!(&word_cnt_q))
                word_cnt_d = word_cnt_q + CNT_W'(1);
            if (err && !(&word_err_cnt_q))
                word_err_cnt_d = word_err_cnt_q + CNT_W'(1);
            bit_err_cnt_d = (bit_sum > CNT_MAX) ? {CNT_W{1'b1}} : CNT_W'(bit_sum);
            if (err) begin
                last_err_d = diff;
                if (!(&burst_len_q))
                    burst_len_d = burst_len_q + BURST_W'(1);
            end else begin
                burst_len_d = '0;
            end
            if (burst_len_d > max_burst_q)
                max_burst_d = burst_len_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (valid && err)
                    state_d = (BURST_TH == 1) ? ALARM : BURST;
            end
            BURST: begin
                if (valid)
                    state_d = !err ? IDLE
                            : (burst_len_d == BURST_W'(BURST_TH)) ? ALARM : BURST;
            end
            ALARM:   state_d = ALARM;
            default: state_d = IDLE;
        endcase
        if (clear)
            state_d = IDLE;
    end

    // FSM: state register, alongside the statistics registers.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            word_cnt_q     <= '0;
            word_err_cnt_q <= '0;
            bit_err_cnt_q  <= '0;
            burst_len_q    <= '0;
            max_burst_q    <= '0;
            last_err_q     <= '0;
        end else begin
            state_q        <= state_d;
            word_cnt_q     <= word_cnt_d;
            word_err_cnt_q <= word_err_cnt_d;
            bit_err_cnt_q  <= bit_err_cnt_d;
            burst_len_q    <= burst_len_d;
            max_burst_q    <= max_burst_d;
            last_err_q     <= last_err_d;
        end
    end

    // FSM: outputs
    always_comb begin
        alarm = (state_q == ALARM);
        state = state_q;
    end

    assign word_cnt     = word_cnt_q;
    assign word_err_cnt = word_err_cnt_q;
    assign bit_err_cnt  = bit_err_cnt_q;
    assign burst_len    = burst_len_q;
    assign max_burst    = max_burst_q;
    assign last_err     = last_err_q;

`ifdef ERR_MONITOR_POS_HIST_EN
    logic [N*HIST_W-1:0] hist_q, hist_d;

    always_comb begin
        hist_d = hist_q;
        if (clear) begin
            hist_d = '0;
        end else if (valid) begin
            for (int i = 0; i < N; i++) begin
                if (diff[i] && !(&hist_q[i*HIST_W +: HIST_W]))
                    hist_d[i*HIST_W +: HIST_W] = hist_q[i*HIST_W +: HIST_W] + HIST_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hist_q <= '0;
        else       hist_q <= hist_d;
    end

    assign pos_hist = hist_q;
`endif

endmodule
